lifo_stack: RTL

//  Synchronous LIFO (stack) buffer, WIDTH bits wide and DEPTH entries deep.

---
 rtl/lifo_stack.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with registered pop data, occupancy and error flags.
// Define LIFO_STICKY_ERR_EN to make overflow/underflow hold until reset.
module lifo_stack #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter int               DEPTH     = 16,
  parameter int               CNT_WIDTH = 5
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     in_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     out_o,
  output logic                 out_valid_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic                 empty, full;
  logic                 wr_en;
  logic [AW-1:0]        wr_idx, top_idx;
  logic [WIDTH-1:0]     wr_data;
  logic                 ovf_evt, unf_evt;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_DEPTH);
  // Only dereferenced when the stack is non-empty, so the wrap at count 0 is harmless.
  assign top_idx = AW'(count_q - CNT_ONE);

  always_comb begin
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = top_idx;
    wr_data     = in_i;
    ovf_evt     = 1'b0;
    unf_evt     = 1'b0;

    case ({push_i, pop_i})
      2'b11: begin
        out_valid_d = 1'b1;
        if (empty) begin
          out_d = in_i;
        end else begin
          out_d = mem_q[top_idx];
          wr_en = 1'b1;
        end
      end
      2'b10: begin
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count_q);
          count_d = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          out_d       = mem_q[top_idx];
          out_valid_d = 1'b1;
          count_d     = count_q - CNT_ONE;
        end
      end
      default: ;
    endcase

`ifdef LIFO_STICKY_ERR_EN
    overflow_d  = overflow_q | ovf_evt;
    underflow_d = underflow_q | unf_evt;
`else
    overflow_d  = ovf_evt;
    underflow_d = unf_evt;
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
      count_q     <= '0;
      out_q       <= INIT;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = count_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule
